systolic_read_engine: RTL and testbench

Responder for the controller's read phase. While `read_start` is held high, it pops matched data/weight vectors from the input FIFOs and skews them per lane into the systolic array edges. When the last vector has fully entered the array it pulses `read_done`. It sits between the input FIFOs and the array, one instance per array.

---
 rtl/systolic_read_engine_if.sv | 29 ++
 rtl/systolic_read_engine.sv | 152 +++++++++++++++
 tb/tb_systolic_read_engine.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_read_engine_if.sv
// Bundle between the read engine, its two input FIFOs, the controller and the array edges.
interface systolic_read_engine_if #(
  parameter int unsigned datawith   = 16,
  parameter int unsigned array_size = 2
);
  localparam int unsigned VW = datawith * array_size;

  logic          read_start;
  logic          read_done;
  logic          d_rempty;
  logic          d_rinc;
  logic [VW-1:0] d_rdata;
  logic          w_rempty;
  logic          w_rinc;
  logic [VW-1:0] w_rdata;
  logic [VW-1:0] data_out;
  logic [VW-1:0] weight_out;
  logic          shift_en;

  modport slave (
    input  read_start, d_rempty, d_rdata, w_rempty, w_rdata,
    output read_done, d_rinc, w_rinc, data_out, weight_out, shift_en
  );

  modport master (
    output read_start, d_rempty, d_rdata, w_rempty, w_rdata,
    input  read_done, d_rinc, w_rinc, data_out, weight_out, shift_en
  );
endinterface

// File: rtl/systolic_read_engine.sv
// Pops matched data/weight vectors during the read phase and feeds them, lane-skewed,
// into the systolic array edges; pulses read_done once the last vector has entered.
module systolic_read_engine #(
  parameter int unsigned datawith   = 16,
  parameter int unsigned array_size = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  systolic_read_engine_if.slave  bus
);
  localparam int unsigned DW = datawith;
  localparam int unsigned N  = array_size;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, DONE, HOLD} state_t;

  state_t          state_q, state_n;
  logic [CW-1:0]   pop_cnt_q, pop_cnt_n;
  logic [CW-1:0]   drain_cnt_q, drain_cnt_n;
  logic            pop_d_q;
  logic            shift_en_q;
  logic            read_done_q;

  logic            pop_c;
  logic            adv_c;
  logic            zero_c;
  logic            clr_c;
  logic            last_c;

  // State register plus the pop/strobe flops that follow it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      pop_cnt_q   <= '0;
      drain_cnt_q <= '0;
      pop_d_q     <= 1'b0;
      shift_en_q  <= 1'b0;
      read_done_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      pop_cnt_q   <= pop_cnt_n;
      drain_cnt_q <= drain_cnt_n;
      pop_d_q     <= pop_c & ~clr_c;
      shift_en_q  <= adv_c;
      read_done_q <= (state_n == DONE);
    end
  end

  // Next-state, pop and advance decisions.
  always_comb begin
    state_n     = state_q;
    pop_cnt_n   = pop_cnt_q;
    drain_cnt_n = drain_cnt_q;
    pop_c       = 1'b0;
    adv_c       = 1'b0;
    zero_c      = 1'b0;
    clr_c       = 1'b0;
    last_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.read_start) begin
          state_n   = FETCH;
          pop_cnt_n = '0;
        end
      end
      FETCH: begin
        pop_c = ~bus.d_rempty & ~bus.w_rempty & (pop_cnt_q < CW'(N));
        adv_c = pop_d_q;
        if (pop_c) pop_cnt_n = pop_cnt_q + CW'(1);
        if (!bus.read_start) begin
          state_n = IDLE;
          clr_c   = 1'b1;
          adv_c   = 1'b0;
        end else if (pop_c && (pop_cnt_q == CW'(N - 1))) begin
          state_n     = DRAIN;
          drain_cnt_n = '0;
        end
      end
      DRAIN: begin
        // First cycle captures the final beat, then N-1 zero advances flush the skew.
        last_c = pop_d_q ? (N == 1) : ((drain_cnt_q + CW'(1)) == CW'(N - 1));
        if (!bus.read_start) begin
          state_n = IDLE;
          clr_c   = 1'b1;
        end else begin
          adv_c  = 1'b1;
          zero_c = ~pop_d_q;
          if (!pop_d_q) drain_cnt_n = drain_cnt_q + CW'(1);
          if (last_c) state_n = DONE;
        end
      end
      DONE: state_n = HOLD;
      HOLD: begin
        if (!bus.read_start) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.d_rinc    = pop_c;
  assign bus.w_rinc    = pop_c;
  assign bus.shift_en  = shift_en_q;
  assign bus.read_done = read_done_q;

  // Per-lane injection: lane i goes through i skew stages before reaching the edge.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] d_in, w_in;
    logic [DW-1:0] d_q, w_q;

    assign d_in = zero_c ? '0 : bus.d_rdata[i*DW +: DW];
    assign w_in = zero_c ? '0 : bus.w_rdata[i*DW +: DW];

    if (i == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (!rst || clr_c) begin
          d_q <= '0;
          w_q <= '0;
        end else if (adv_c) begin
          d_q <= d_in;
          w_q <= w_in;
        end
      end
    end else begin : g_skew
      logic [DW-1:0] d_sk [i];
      logic [DW-1:0] w_sk [i];

      always_ff @(posedge clk) begin
        if (!rst || clr_c) begin
          for (int j = 0; j < i; j++) begin
            d_sk[j] <= '0;
            w_sk[j] <= '0;
          end
          d_q <= '0;
          w_q <= '0;
        end else if (adv_c) begin
          d_sk[0] <= d_in;
          w_sk[0] <= w_in;
          for (int j = 1; j < i; j++) begin
            d_sk[j] <= d_sk[j-1];
            w_sk[j] <= w_sk[j-1];
          end
          d_q <= d_sk[i-1];
          w_q <= w_sk[i-1];
        end
      end
    end

    assign bus.data_out[i*DW +: DW]   = d_q;
    assign bus.weight_out[i*DW +: DW] = w_q;
  end
endmodule

// File: tb/tb_systolic_read_engine.sv
// Scoreboard bench for systolic_read_engine: N=2 loads (nominal, stalled, held, aborted, reset)
// and an N=1 load, with a negedge monitor comparing against queued expectations.
module tb_systolic_read_engine;
  typedef struct {
    int          cyc;
    logic [31:0] d;
    logic [31:0] w;
  } vec_t;

  typedef struct {
    int          cyc;
    logic        rinc;
    logic        sh;
    logic        dn;
    logic [15:0] d;
    logic [15:0] w;
  } n1_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  systolic_read_engine_if #(.datawith(16), .array_size(2)) bus2 ();
  systolic_read_engine_if #(.datawith(16), .array_size(1)) bus1 ();

  systolic_read_engine #(.datawith(16), .array_size(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave));
  systolic_read_engine #(.datawith(16), .array_size(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO models: head becomes valid the cycle after a pop.
  logic [31:0] d_mem [16];
  logic [31:0] w_mem [16];
  int d_wr = 0, d_rd = 0, w_wr = 0, w_rd = 0;
  bit d_hold = 1'b0;
  int p1_wr = 1, p1_rd = 0;

  assign bus2.d_rempty = d_hold || (d_rd == d_wr);
  assign bus2.w_rempty = (w_rd == w_wr);
  assign bus1.d_rempty = (p1_rd == p1_wr);
  assign bus1.w_rempty = (p1_rd == p1_wr);

  always @(posedge clk) begin
    if (bus2.d_rinc) begin
      bus2.d_rdata <= d_mem[d_rd % 16];
      d_rd <= d_rd + 1;
    end
    if (bus2.w_rinc) begin
      bus2.w_rdata <= w_mem[w_rd % 16];
      w_rd <= w_rd + 1;
    end
    if (bus1.d_rinc) begin
      bus1.d_rdata <= 16'd9;
      bus1.w_rdata <= 16'd10;
      p1_rd <= p1_rd + 1;
    end
  end

  int   pop_q  [$];
  vec_t sh_q   [$];
  int   done_q [$];
  int   zero_q [$];
  n1_t  n1_q   [$];
  int   checks = 0;
  int   errors = 0;

  bit   now;
  vec_t ev;
  n1_t  e1;

  // Monitor: every output event or scheduled expectation is one comparison.
  always @(negedge clk) begin
    now = (pop_q.size() > 0) && (pop_q[0] == cyc);
    if (bus2.d_rinc || bus2.w_rinc || now) begin
      checks++;
      if (!(bus2.d_rinc && bus2.w_rinc && now)) begin
        errors++;
        $display("FAIL pop cyc=%0d: d_rinc=%b w_rinc=%b, expected pop=%b", cyc, bus2.d_rinc, bus2.w_rinc, now);
      end
      if (now) void'(pop_q.pop_front());
    end

    now = (sh_q.size() > 0) && (sh_q[0].cyc == cyc);
    if (bus2.shift_en || now) begin
      checks++;
      ev = '{cyc: 0, d: 32'h0, w: 32'h0};
      if (now) ev = sh_q.pop_front();
      if (!(bus2.shift_en && now && bus2.data_out == ev.d && bus2.weight_out == ev.w)) begin
        errors++;
        $display("FAIL shift cyc=%0d: shift_en=%b data_out=%h weight_out=%h, expected shift=%b data_out=%h weight_out=%h",
                 cyc, bus2.shift_en, bus2.data_out, bus2.weight_out, now, ev.d, ev.w);
      end
    end

    now = (done_q.size() > 0) && (done_q[0] == cyc);
    if (bus2.read_done || now) begin
      checks++;
      if (!(bus2.read_done && now)) begin
        errors++;
        $display("FAIL read_done cyc=%0d: read_done=%b, expected %b", cyc, bus2.read_done, now);
      end
      if (now) void'(done_q.pop_front());
    end

    if ((zero_q.size() > 0) && (zero_q[0] == cyc)) begin
      void'(zero_q.pop_front());
      checks++;
      if (bus2.data_out != '0 || bus2.weight_out != '0 || bus2.shift_en || bus2.read_done || bus2.d_rinc) begin
        errors++;
        $display("FAIL cleared cyc=%0d: data_out=%h weight_out=%h shift_en=%b read_done=%b d_rinc=%b, expected all 0",
                 cyc, bus2.data_out, bus2.weight_out, bus2.shift_en, bus2.read_done, bus2.d_rinc);
      end
    end

    if ((n1_q.size() > 0) && (n1_q[0].cyc == cyc)) begin
      e1 = n1_q.pop_front();
      checks++;
      if (bus1.d_rinc != e1.rinc || bus1.shift_en != e1.sh || bus1.read_done != e1.dn ||
          bus1.data_out != e1.d || bus1.weight_out != e1.w) begin
        errors++;
        $display("FAIL n1 cyc=%0d: rinc=%b shift=%b done=%b data=%0d weight=%0d, expected rinc=%b shift=%b done=%b data=%0d weight=%0d",
                 cyc, bus1.d_rinc, bus1.shift_en, bus1.read_done, bus1.data_out, bus1.weight_out,
                 e1.rinc, e1.sh, e1.dn, e1.d, e1.w);
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // D0={1,2} D1={3,4} W0={5,6} W1={7,8}, lane 0 in the low half.
  task automatic preload2();
    d_mem[d_wr % 16]       = 32'h0002_0001;
    d_mem[(d_wr + 1) % 16] = 32'h0004_0003;
    w_mem[w_wr % 16]       = 32'h0006_0005;
    w_mem[(w_wr + 1) % 16] = 32'h0008_0007;
    d_wr = d_wr + 2;
    w_wr = w_wr + 2;
  endtask

  task automatic start2(output int base);
    @(posedge clk);
    #1;
    base = cyc;
    bus2.read_start = 1'b1;
  endtask

  task automatic push_load(input int base, input bit stall);
    pop_q.push_back(base + 1);
    pop_q.push_back(base + (stall ? 5 : 2));
    sh_q.push_back('{cyc: base + 3,                d: 32'h0000_0001, w: 32'h0000_0005});
    sh_q.push_back('{cyc: base + (stall ? 7 : 4),  d: 32'h0002_0003, w: 32'h0006_0007});
    sh_q.push_back('{cyc: base + (stall ? 8 : 5),  d: 32'h0004_0000, w: 32'h0008_0000});
    done_q.push_back(base + (stall ? 8 : 5));
  endtask

  int base;

  initial begin
    bus2.read_start = 1'b0;
    bus1.read_start = 1'b0;
    rst = 1'b0;
    zero_q.push_back(2);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Nominal load, then read_start held three cycles past read_done.
    preload2();
    start2(base);
    push_load(base, 1'b0);
    wait_until(base + 9);
    bus2.read_start = 1'b0;
    wait_until(base + 11);

    // Fresh load after read_start toggled low.
    preload2();
    start2(base);
    push_load(base, 1'b0);
    wait_until(base + 6);
    bus2.read_start = 1'b0;
    wait_until(base + 8);

    // Data FIFO empty during c2..c4.
    preload2();
    start2(base);
    push_load(base, 1'b1);
    wait_until(base + 2);
    d_hold = 1'b1;
    wait_until(base + 5);
    d_hold = 1'b0;
    wait_until(base + 9);
    bus2.read_start = 1'b0;
    wait_until(base + 11);

    // Abort at c3.
    preload2();
    start2(base);
    pop_q.push_back(base + 1);
    pop_q.push_back(base + 2);
    sh_q.push_back('{cyc: base + 3, d: 32'h0000_0001, w: 32'h0000_0005});
    zero_q.push_back(base + 4);
    zero_q.push_back(base + 6);
    wait_until(base + 3);
    bus2.read_start = 1'b0;
    wait_until(base + 9);

    // Reset in the middle of DRAIN.
    preload2();
    start2(base);
    pop_q.push_back(base + 1);
    pop_q.push_back(base + 2);
    sh_q.push_back('{cyc: base + 3, d: 32'h0000_0001, w: 32'h0000_0005});
    zero_q.push_back(base + 4);
    wait_until(base + 3);
    rst = 1'b0;
    bus2.read_start = 1'b0;
    wait_until(base + 5);
    rst = 1'b1;
    zero_q.push_back(base + 7);
    wait_until(base + 9);

    // N=1 single vector {9}, weight {10}.
    @(posedge clk);
    #1;
    base = cyc;
    bus1.read_start = 1'b1;
    n1_q.push_back('{cyc: base,     rinc: 1'b0, sh: 1'b0, dn: 1'b0, d: 16'd0, w: 16'd0});
    n1_q.push_back('{cyc: base + 1, rinc: 1'b1, sh: 1'b0, dn: 1'b0, d: 16'd0, w: 16'd0});
    n1_q.push_back('{cyc: base + 2, rinc: 1'b0, sh: 1'b0, dn: 1'b0, d: 16'd0, w: 16'd0});
    n1_q.push_back('{cyc: base + 3, rinc: 1'b0, sh: 1'b1, dn: 1'b1, d: 16'd9, w: 16'd10});
    n1_q.push_back('{cyc: base + 4, rinc: 1'b0, sh: 1'b0, dn: 1'b0, d: 16'd9, w: 16'd10});
    wait_until(base + 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
